// File: rtl/slot_allocator.sv
// Insert/delete control stage in front of flag_register: reads the three candidate buckets, picks or clears a slot,
// writes the new mask back and returns a response. Clears the whole flag memory after reset.
module slot_allocator #(
  parameter int SIZE        = 10,
  parameter int BUCKET_SIZE = 4,
  localparam int WAY_W      = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_op,
  input  logic [SIZE-1:0]        req_adr_0,
  input  logic [SIZE-1:0]        req_adr_1,
  input  logic [SIZE-1:0]        req_adr_2,
  input  logic [1:0]             req_sel,
  input  logic [WAY_W-1:0]       req_way,
  output logic [SIZE-1:0]        flag_read_adr_0,
  output logic [SIZE-1:0]        flag_read_adr_1,
  output logic [SIZE-1:0]        flag_read_adr_2,
  input  logic [BUCKET_SIZE-1:0] flag_in_0,
  input  logic [BUCKET_SIZE-1:0] flag_in_1,
  input  logic [BUCKET_SIZE-1:0] flag_in_2,
  output logic [SIZE-1:0]        flag_write_adr,
  output logic                   flag_write_en,
  output logic [BUCKET_SIZE-1:0] flag_write_is_valid,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_ok,
  output logic [1:0]             resp_sel,
  output logic [WAY_W-1:0]       resp_way,
  output logic [SIZE-1:0]        resp_adr,
  output logic                   init_done
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]             state_r;
  logic [SIZE-1:0]        init_cnt_r;
  logic                   s1_valid_r;
  logic                   s1_op_r;
  logic [SIZE-1:0]        s1_adr0_r, s1_adr1_r, s1_adr2_r;
  logic [1:0]             s1_sel_r;
  logic [WAY_W-1:0]       s1_way_r;
  logic                   fwd_valid_r;
  logic [SIZE-1:0]        fwd_adr_r;
  logic [BUCKET_SIZE-1:0] fwd_data_r;

  logic                   commit_s, accept_s;
  logic [BUCKET_SIZE-1:0] eff0_s, eff1_s, eff2_s, del_mask_s;
  logic [SIZE-1:0]        del_adr_s;
  logic                   dec_write_s, dec_ok_s;
  logic [1:0]             dec_sel_s;
  logic [WAY_W-1:0]       dec_way_s;
  logic [SIZE-1:0]        dec_adr_s;
  logic [BUCKET_SIZE-1:0] dec_mask_s;
  logic                   wr_en_s;
  logic [SIZE-1:0]        wr_adr_s;
  logic [BUCKET_SIZE-1:0] wr_data_s;

  function automatic logic [WAY_W-1:0] lowest_zero(input logic [BUCKET_SIZE-1:0] m);
    logic [WAY_W-1:0] r;
    r = {WAY_W{1'b0}};
    for (int i = BUCKET_SIZE - 1; i >= 0; i--) begin
      r = (!m[i]) ? WAY_W'(i) : r;
    end
    return r;
  endfunction

  function automatic logic [BUCKET_SIZE-1:0] onehot(input logic [WAY_W-1:0] w);
    logic [BUCKET_SIZE-1:0] r;
    r    = {BUCKET_SIZE{1'b0}};
    r[w] = 1'b1;
    return r;
  endfunction

  // Handshake and forwarding-corrected bucket masks
  always_comb begin
    commit_s  = s1_valid_r && (!resp_valid || resp_ready);
    req_ready = (state_r == ST_RUN) && (!s1_valid_r || commit_s);
    accept_s  = req_valid && req_ready;
    eff0_s    = (fwd_valid_r && fwd_adr_r == s1_adr0_r) ? fwd_data_r : flag_in_0;
    eff1_s    = (fwd_valid_r && fwd_adr_r == s1_adr1_r) ? fwd_data_r : flag_in_1;
    eff2_s    = (fwd_valid_r && fwd_adr_r == s1_adr2_r) ? fwd_data_r : flag_in_2;
  end

  // Stalled S1 re-reads its own buckets so the data is fresh when it finally commits
  always_comb begin
    if (accept_s) begin
      flag_read_adr_0 = req_adr_0;
      flag_read_adr_1 = req_adr_1;
      flag_read_adr_2 = req_adr_2;
    end else begin
      flag_read_adr_0 = s1_adr0_r;
      flag_read_adr_1 = s1_adr1_r;
      flag_read_adr_2 = s1_adr2_r;
    end
  end

  // Delete target bucket selection
  always_comb begin
    case (s1_sel_r)
      2'd0:    begin del_mask_s = eff0_s; del_adr_s = s1_adr0_r; end
      2'd1:    begin del_mask_s = eff1_s; del_adr_s = s1_adr1_r; end
      2'd2:    begin del_mask_s = eff2_s; del_adr_s = s1_adr2_r; end
      default: begin del_mask_s = {BUCKET_SIZE{1'b0}}; del_adr_s = s1_adr0_r; end
    endcase
  end

  // Slot decision for the request in S1
  always_comb begin
    dec_write_s = 1'b0;
    dec_ok_s    = 1'b0;
    dec_sel_s   = 2'd0;
    dec_way_s   = {WAY_W{1'b0}};
    dec_adr_s   = s1_adr0_r;
    dec_mask_s  = {BUCKET_SIZE{1'b0}};
    if (s1_op_r == 1'b0) begin
      if (!(&eff0_s)) begin
        dec_write_s = 1'b1;
        dec_ok_s    = 1'b1;
        dec_way_s   = lowest_zero(eff0_s);
        dec_mask_s  = eff0_s | onehot(lowest_zero(eff0_s));
      end else if (!(&eff1_s)) begin
        dec_write_s = 1'b1;
        dec_ok_s    = 1'b1;
        dec_sel_s   = 2'd1;
        dec_adr_s   = s1_adr1_r;
        dec_way_s   = lowest_zero(eff1_s);
        dec_mask_s  = eff1_s | onehot(lowest_zero(eff1_s));
      end else if (!(&eff2_s)) begin
        dec_write_s = 1'b1;
        dec_ok_s    = 1'b1;
        dec_sel_s   = 2'd2;
        dec_adr_s   = s1_adr2_r;
        dec_way_s   = lowest_zero(eff2_s);
        dec_mask_s  = eff2_s | onehot(lowest_zero(eff2_s));
      end else begin
        dec_write_s = 1'b0;
      end
    end else begin
      dec_sel_s = s1_sel_r;
      dec_way_s = s1_way_r;
      dec_adr_s = del_adr_s;
      if (del_mask_s[s1_way_r]) begin
        dec_write_s = 1'b1;
        dec_ok_s    = 1'b1;
        dec_mask_s  = del_mask_s & ~onehot(s1_way_r);
      end else begin
        dec_write_s = 1'b0;
      end
    end
  end

  // Flag write port: clear sweep during INIT, one write per committed request afterwards
  always_comb begin
    if (state_r == ST_INIT) begin
      wr_en_s   = 1'b1;
      wr_adr_s  = init_cnt_r;
      wr_data_s = {BUCKET_SIZE{1'b0}};
    end else if (commit_s && dec_write_s) begin
      wr_en_s   = 1'b1;
      wr_adr_s  = dec_adr_s;
      wr_data_s = dec_mask_s;
    end else begin
      wr_en_s   = 1'b0;
      wr_adr_s  = {SIZE{1'b0}};
      wr_data_s = {BUCKET_SIZE{1'b0}};
    end
  end

  // Hold the write port quiet while reset is asserted
  always_comb begin
    if (reset) begin
      flag_write_en       = wr_en_s;
      flag_write_adr      = wr_adr_s;
      flag_write_is_valid = wr_data_s;
    end else begin
      flag_write_en       = 1'b0;
      flag_write_adr      = {SIZE{1'b0}};
      flag_write_is_valid = {BUCKET_SIZE{1'b0}};
    end
  end

  // INIT sweep counter and state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_INIT;
      init_cnt_r <= {SIZE{1'b0}};
      init_done  <= 1'b0;
    end else if (state_r == ST_INIT) begin
      init_cnt_r <= init_cnt_r + {{(SIZE-1){1'b0}}, 1'b1};
      if (init_cnt_r == {SIZE{1'b1}}) begin
        state_r   <= ST_RUN;
        init_done <= 1'b1;
      end
    end
  end

  // S1 request register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 1'b0;
      s1_adr0_r  <= {SIZE{1'b0}};
      s1_adr1_r  <= {SIZE{1'b0}};
      s1_adr2_r  <= {SIZE{1'b0}};
      s1_sel_r   <= 2'd0;
      s1_way_r   <= {WAY_W{1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= req_op;
      s1_adr0_r  <= req_adr_0;
      s1_adr1_r  <= req_adr_1;
      s1_adr2_r  <= req_adr_2;
      s1_sel_r   <= req_sel;
      s1_way_r   <= req_way;
    end else if (commit_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Forward the last write for one cycle to cover the memory's read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_valid_r <= 1'b0;
      fwd_adr_r   <= {SIZE{1'b0}};
      fwd_data_r  <= {BUCKET_SIZE{1'b0}};
    end else begin
      fwd_valid_r <= wr_en_s;
      fwd_adr_r   <= wr_adr_s;
      fwd_data_r  <= wr_data_s;
    end
  end

  // Response register, held until consumed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_ok    <= 1'b0;
      resp_sel   <= 2'd0;
      resp_way   <= {WAY_W{1'b0}};
      resp_adr   <= {SIZE{1'b0}};
    end else if (commit_s) begin
      resp_valid <= 1'b1;
      resp_ok    <= dec_ok_s;
      resp_sel   <= dec_sel_s;
      resp_way   <= dec_way_s;
      resp_adr   <= dec_adr_s;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slot_allocator.sv
// Directed bench for slot_allocator with a behavioural flag_register (1-cycle read latency).
module tb_slot_allocator;
  localparam int SIZE = 10;
  localparam int BS   = 4;
  localparam int WW   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid, req_ready, req_op;
  logic [SIZE-1:0] req_adr_0, req_adr_1, req_adr_2;
  logic [1:0]      req_sel;
  logic [WW-1:0]   req_way;
  logic [SIZE-1:0] flag_read_adr_0, flag_read_adr_1, flag_read_adr_2;
  logic [BS-1:0]   flag_in_0, flag_in_1, flag_in_2;
  logic [SIZE-1:0] flag_write_adr;
  logic            flag_write_en;
  logic [BS-1:0]   flag_write_is_valid;
  logic            resp_valid, resp_ready, resp_ok;
  logic [1:0]      resp_sel;
  logic [WW-1:0]   resp_way;
  logic [SIZE-1:0] resp_adr;
  logic            init_done;

  int checks   = 0;
  int failures = 0;

  logic [BS-1:0] mem [0:(1<<SIZE)-1];

  slot_allocator #(.SIZE(SIZE), .BUCKET_SIZE(BS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_adr_0(req_adr_0), .req_adr_1(req_adr_1), .req_adr_2(req_adr_2),
    .req_sel(req_sel), .req_way(req_way),
    .flag_read_adr_0(flag_read_adr_0), .flag_read_adr_1(flag_read_adr_1), .flag_read_adr_2(flag_read_adr_2),
    .flag_in_0(flag_in_0), .flag_in_1(flag_in_1), .flag_in_2(flag_in_2),
    .flag_write_adr(flag_write_adr), .flag_write_en(flag_write_en), .flag_write_is_valid(flag_write_is_valid),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ok(resp_ok),
    .resp_sel(resp_sel), .resp_way(resp_way), .resp_adr(resp_adr),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Behavioural flag memory: read returns old data on a same-cycle write
  always @(posedge clk) begin
    flag_in_0 <= mem[flag_read_adr_0];
    flag_in_1 <= mem[flag_read_adr_1];
    flag_in_2 <= mem[flag_read_adr_2];
    if (flag_write_en) mem[flag_write_adr] <= flag_write_is_valid;
  end

  task automatic test_sweep(input string tag);
    for (int i = 0; i < (1 << SIZE); i++) begin
      @(negedge clk);
      checks++;
      if (flag_write_en !== 1'b1 || flag_write_adr !== SIZE'(i) || flag_write_is_valid !== 4'b0000
          || req_ready !== 1'b0 || init_done !== 1'b0) begin
        failures++;
        $display("FAIL %s_sweep cycle %0d: en=%b adr=%0d data=%b ready=%b done=%b, want en=1 adr=%0d data=0000 ready=0 done=0",
                 tag, i, flag_write_en, flag_write_adr, flag_write_is_valid, req_ready, init_done, i);
      end
    end
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1 || flag_write_en !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: init_done=%b en=%b ready=%b, want 1 0 1", tag, init_done, flag_write_en, req_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_sel = 2'd0; req_way = 2'd0;
    req_adr_0 = '0; req_adr_1 = '0; req_adr_2 = '0; resp_ready = 1'b1;
    #12;
    checks++;
    if ({req_ready, resp_valid, resp_ok, resp_sel, resp_way, resp_adr, flag_write_en, flag_write_adr,
         flag_write_is_valid, flag_read_adr_0, flag_read_adr_1, flag_read_adr_2, init_done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: some output nonzero (ready=%b rv=%b wen=%b wadr=%0d done=%b), want all 0",
               req_ready, resp_valid, flag_write_en, flag_write_adr, init_done);
    end
    @(posedge clk); #1 reset = 1'b1;
    test_sweep("init");
  endtask

  task automatic test_insert;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 1'b0; req_adr_0 = 10'd5; req_adr_1 = 10'd9; req_adr_2 = 10'd13;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL ins_accept: ready=%b want 1", req_ready); end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (flag_write_en !== 1'b1 || flag_write_adr !== 10'd5 || flag_write_is_valid !== 4'b0001) begin
      failures++;
      $display("FAIL ins_write: en=%b adr=%0d data=%b, want 1 5 0001", flag_write_en, flag_write_adr, flag_write_is_valid);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_ok !== 1'b1 || resp_sel !== 2'd0 || resp_way !== 2'd0 || resp_adr !== 10'd5) begin
      failures++;
      $display("FAIL ins_resp: v=%b ok=%b sel=%0d way=%0d adr=%0d, want 1 1 0 0 5",
               resp_valid, resp_ok, resp_sel, resp_way, resp_adr);
    end
  endtask

  task automatic test_back_to_back;
    int tab [12]  = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
    int way [12]  = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    logic [3:0] msk [12] = '{4'b0011, 4'b0111, 4'b1111, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};
    int adr_of [4] = '{5, 9, 13, 0};
    int r;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 12); req_op = 1'b0; req_adr_0 = 10'd5; req_adr_1 = 10'd9; req_adr_2 = 10'd13;
      @(negedge clk);
      if (c < 12) begin
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready c%0d: %b want 1", c, req_ready); end
      end
      if (c >= 1 && c <= 12) begin
        r = c - 1;
        checks++;
        if (tab[r] == 3) begin
          if (flag_write_en !== 1'b0) begin
            failures++; $display("FAIL b2b_full_write r%0d: en=%b want 0", r, flag_write_en);
          end
        end else if (flag_write_en !== 1'b1 || flag_write_adr !== SIZE'(adr_of[tab[r]]) || flag_write_is_valid !== msk[r]) begin
          failures++;
          $display("FAIL b2b_write r%0d: en=%b adr=%0d data=%b, want 1 %0d %b",
                   r, flag_write_en, flag_write_adr, flag_write_is_valid, adr_of[tab[r]], msk[r]);
        end
      end
      if (c >= 2) begin
        r = c - 2;
        checks++;
        if (tab[r] == 3) begin
          if (resp_valid !== 1'b1 || resp_ok !== 1'b0) begin
            failures++; $display("FAIL b2b_full_resp: v=%b ok=%b want 1 0", resp_valid, resp_ok);
          end
        end else if (resp_valid !== 1'b1 || resp_ok !== 1'b1 || resp_sel !== 2'(tab[r]) || resp_way !== 2'(way[r])
                     || resp_adr !== SIZE'(adr_of[tab[r]])) begin
          failures++;
          $display("FAIL b2b_resp r%0d: v=%b ok=%b sel=%0d way=%0d adr=%0d, want 1 1 %0d %0d %0d",
                   r, resp_valid, resp_ok, resp_sel, resp_way, resp_adr, tab[r], way[r], adr_of[tab[r]]);
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_delete;
    // op, a0, a1, a2, sel, way, write?, wadr, wdata, ok
    int         v_op [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int         v_a  [8] = '{5, 5, 5, 5, 5, 5, 5, 7};
    int         v_sl [8] = '{1, 1, 1, 1, 1, 3, 0, 0};
    int         v_wy [8] = '{0, 1, 3, 2, 2, 0, 3, 0};
    int         v_wr [8] = '{1, 1, 1, 1, 0, 0, 1, 1};
    int         v_wa [8] = '{9, 9, 9, 9, 0, 0, 5, 7};
    logic [3:0] v_wd [8] = '{4'b1110, 4'b1100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b0001};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = v_op[i][0]; req_sel = 2'(v_sl[i]); req_way = 2'(v_wy[i]);
      if (v_a[i] == 7) begin
        req_adr_0 = 10'd7; req_adr_1 = 10'd7; req_adr_2 = 10'd7;
      end else begin
        req_adr_0 = 10'd5; req_adr_1 = 10'd9; req_adr_2 = 10'd13;
      end
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (v_wr[i] == 0) begin
        if (flag_write_en !== 1'b0) begin failures++; $display("FAIL del_nowrite v%0d: en=%b want 0", i, flag_write_en); end
      end else if (flag_write_en !== 1'b1 || flag_write_adr !== SIZE'(v_wa[i]) || flag_write_is_valid !== v_wd[i]) begin
        failures++;
        $display("FAIL del_write v%0d: en=%b adr=%0d data=%b, want 1 %0d %b",
                 i, flag_write_en, flag_write_adr, flag_write_is_valid, v_wa[i], v_wd[i]);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_ok !== v_wr[i][0]) begin
        failures++; $display("FAIL del_resp_ok v%0d: v=%b ok=%b want 1 %0d", i, resp_valid, resp_ok, v_wr[i]);
      end else if (v_wr[i] == 1) begin
        checks++;
        if (resp_sel !== 2'(v_sl[i]) || resp_way !== 2'(v_wy[i]) || resp_adr !== SIZE'(v_wa[i])) begin
          failures++;
          $display("FAIL del_resp v%0d: sel=%0d way=%0d adr=%0d, want %0d %0d %0d",
                   i, resp_sel, resp_way, resp_adr, v_sl[i], v_wy[i], v_wa[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int wcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      req_valid = (c <= 5); req_op = 1'b0; req_adr_0 = 10'd100; req_adr_1 = 10'd200; req_adr_2 = 10'd300;
      resp_ready = (c >= 5);
      @(negedge clk);
      if (flag_write_en === 1'b1) wcnt++;
      checks++;
      case (c)
        0: if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_c0 ready=%b want 1", req_ready); end
        1: if (flag_write_en !== 1'b1 || flag_write_adr !== 10'd100 || flag_write_is_valid !== 4'b0001 || req_ready !== 1'b1) begin
             failures++; $display("FAIL bp_c1 en=%b adr=%0d data=%b ready=%b, want 1 100 0001 1",
                                  flag_write_en, flag_write_adr, flag_write_is_valid, req_ready);
           end
        2, 3, 4: if (flag_write_en !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_ok !== 1'b1
                     || resp_adr !== 10'd100 || resp_way !== 2'd0 || resp_sel !== 2'd0) begin
             failures++; $display("FAIL bp_stall c%0d en=%b ready=%b v=%b ok=%b adr=%0d way=%0d, want 0 0 1 1 100 0",
                                  c, flag_write_en, req_ready, resp_valid, resp_ok, resp_adr, resp_way);
           end
        5: if (flag_write_en !== 1'b1 || flag_write_adr !== 10'd100 || flag_write_is_valid !== 4'b0011 || req_ready !== 1'b1) begin
             failures++; $display("FAIL bp_c5 en=%b adr=%0d data=%b ready=%b, want 1 100 0011 1",
                                  flag_write_en, flag_write_adr, flag_write_is_valid, req_ready);
           end
        6: if (resp_valid !== 1'b1 || resp_way !== 2'd1 || flag_write_en !== 1'b1 || flag_write_is_valid !== 4'b0111) begin
             failures++; $display("FAIL bp_c6 v=%b way=%0d en=%b data=%b, want 1 1 1 0111",
                                  resp_valid, resp_way, flag_write_en, flag_write_is_valid);
           end
        default: if (resp_valid !== 1'b1 || resp_way !== 2'd2 || flag_write_en !== 1'b0) begin
             failures++; $display("FAIL bp_c7 v=%b way=%0d en=%b, want 1 2 0", resp_valid, resp_way, flag_write_en);
           end
      endcase
    end
    req_valid = 1'b0;
    checks++;
    if (wcnt != 3) begin failures++; $display("FAIL bp_write_count: %0d want 3", wcnt); end
  endtask

  task automatic test_reset_midstream;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 1'b0; req_adr_0 = 10'd400; req_adr_1 = 10'd401; req_adr_2 = 10'd402;
      resp_ready = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
      failures++; $display("FAIL mid_full: v=%b ready=%b want 1 0", resp_valid, req_ready);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_ok, resp_sel, resp_way, resp_adr, flag_write_en, flag_write_adr,
         flag_write_is_valid, flag_read_adr_0, flag_read_adr_1, flag_read_adr_2, init_done} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: ready=%b rv=%b ok=%b radr0=%0d wen=%b done=%b, want all 0",
               req_ready, resp_valid, resp_ok, flag_read_adr_0, flag_write_en, init_done);
    end
    @(posedge clk); @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b1; reset = 1'b1;
    test_sweep("reinit");
  endtask

  initial begin
    test_reset;
    test_insert;
    test_back_to_back;
    test_delete;
    test_backpressure;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
